mult_requester: RTL and testbench

- Initiator side of the shift-add multiplier's valid/acknowledge handshake.
- Buffers operand pairs from upstream logic in a small FIFO and issues them one at a time: drives Valid_Data with Data_A/Data_B.
- Waits for the multiplier's done indication, captures the 2*WIDTH product, pulses Ack and presents the result downstream.
- Replaces the free-running stimulus generator as the real producer/consumer for the multiplier core.

---
 rtl/mult_requester_pkg.sv | 20 ++
 rtl/mult_requester_req_fifo.sv | 71 +++++++
 rtl/mult_requester.sv | 151 +++++++++++++++
 tb/tb_mult_requester.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_requester_pkg.sv
// rtl/mult_requester_pkg.sv - shared types and defaults for the multiplier requester
package mult_requester_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_TIMEOUT    = 128;

  typedef enum logic [1:0] {
    REQ_IDLE    = 2'd0,
    REQ_ISSUE   = 2'd1,
    REQ_ACK     = 2'd2,
    REQ_RELEASE = 2'd3
  } reqState_t;

  // The multiplier product is always twice the operand width.
  function automatic int prodWidth(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/mult_requester_req_fifo.sv
// rtl/mult_requester_req_fifo.sv - operand-pair buffer ahead of the issue state machine
module req_fifo
  import mult_requester_pkg::*;
#(
  parameter int DW    = prodWidth(DEF_WIDTH),
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic [AW:0]   countNext;
  logic          doPush;
  logic          doPop;

  // A push into a full buffer is only allowed when the head leaves in the same cycle.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign dout   = mem[rdPtr];

  // Occupancy after this cycle; simultaneous push and pop leave it unchanged.
  always_comb begin
    countNext = count;
    if (doPush && !doPop) begin
      countNext = count + 1'b1;
    end else if (doPop && !doPush) begin
      countNext = count - 1'b1;
    end
  end

  // Storage array carries no reset; pointers and flags decide what is valid.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= din;
    end
  end

  // Pointers wrap naturally because the depth is a power of two; flags are registered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      count <= countNext;
      full  <= (countNext == (AW + 1)'(DEPTH));
      empty <= (countNext == '0);
    end
  end

endmodule

// File: rtl/mult_requester.sv
// rtl/mult_requester.sv - issues buffered operand pairs to the multiplier and captures products
module mult_requester
  import mult_requester_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          iLoad,
  input  logic [WIDTH-1:0]              iOperand_A,
  input  logic [WIDTH-1:0]              iOperand_B,
  output logic                          oFull,
  output logic                          oValid_Data,
  output logic [WIDTH-1:0]              oData_A,
  output logic [WIDTH-1:0]              oData_B,
  input  logic                          iDone,
  input  logic [prodWidth(WIDTH)-1:0]   iProd,
  output logic                          oAck,
  output logic [prodWidth(WIDTH)-1:0]   oResult,
  output logic                          oResult_Valid,
  output logic                          oBusy,
  output logic                          oTimeout
);

  localparam int PW = prodWidth(WIDTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

  reqState_t state;
  reqState_t stateNext;

  logic [CW-1:0]      waitCnt;
  logic [CW-1:0]      waitCntNext;
  logic               validNext;
  logic [WIDTH-1:0]   dataANext;
  logic [WIDTH-1:0]   dataBNext;
  logic               ackNext;
  logic [PW-1:0]      resultNext;
  logic               resultValidNext;
  logic               timeoutNext;

  logic               fifoPush;
  logic               fifoPop;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [2*WIDTH-1:0] fifoDin;
  logic [2*WIDTH-1:0] fifoDout;

  assign fifoDin  = {iOperand_A, iOperand_B};
  assign fifoPush = iLoad && (!fifoFull || fifoPop);
  assign oFull    = fifoFull;

  req_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) uReqFifo (
    .clk    (Clock),
    .resetn (Reset),
    .push   (fifoPush),
    .pop    (fifoPop),
    .din    (fifoDin),
    .dout   (fifoDout),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  // Next state and next output values; every register holds unless a transition changes it.
  always_comb begin
    stateNext       = state;
    fifoPop         = 1'b0;
    waitCntNext     = waitCnt;
    validNext       = oValid_Data;
    dataANext       = oData_A;
    dataBNext       = oData_B;
    ackNext         = 1'b0;
    resultNext      = oResult;
    resultValidNext = 1'b0;
    timeoutNext     = oTimeout;
    unique case (state)
      REQ_IDLE: begin
        // iDone is deliberately not looked at here.
        if (!fifoEmpty) begin
          fifoPop     = 1'b1;
          stateNext   = REQ_ISSUE;
          dataANext   = fifoDout[2*WIDTH-1:WIDTH];
          dataBNext   = fifoDout[WIDTH-1:0];
          validNext   = 1'b1;
          waitCntNext = '0;
        end
      end
      REQ_ISSUE: begin
        // A product arriving on the last allowed cycle still wins over the abort.
        if (iDone) begin
          stateNext       = REQ_ACK;
          resultNext      = iProd;
          resultValidNext = 1'b1;
          ackNext         = 1'b1;
          validNext       = 1'b0;
        end else if (waitCnt == CNT_LIMIT) begin
          stateNext   = REQ_IDLE;
          validNext   = 1'b0;
          timeoutNext = 1'b1;
        end else begin
          waitCntNext = waitCnt + 1'b1;
        end
      end
      REQ_ACK: begin
        stateNext = REQ_RELEASE;
      end
      REQ_RELEASE: begin
        // Wait for the multiplier to drop iDone so one product is never acknowledged twice.
        if (!iDone) begin
          stateNext = REQ_IDLE;
        end
      end
      default: begin
        stateNext = REQ_IDLE;
      end
    endcase
  end

  // State, counter and all outputs are registered; reset clears everything from any state.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state         <= REQ_IDLE;
      waitCnt       <= '0;
      oValid_Data   <= 1'b0;
      oData_A       <= '0;
      oData_B       <= '0;
      oAck          <= 1'b0;
      oResult       <= '0;
      oResult_Valid <= 1'b0;
      oBusy         <= 1'b0;
      oTimeout      <= 1'b0;
    end else begin
      state         <= stateNext;
      waitCnt       <= waitCntNext;
      oValid_Data   <= validNext;
      oData_A       <= dataANext;
      oData_B       <= dataBNext;
      oAck          <= ackNext;
      oResult       <= resultNext;
      oResult_Valid <= resultValidNext;
      oBusy         <= (stateNext != REQ_IDLE);
      oTimeout      <= timeoutNext;
    end
  end

endmodule

// File: tb/tb_mult_requester.sv
// tb/tb_mult_requester.sv - self-checking bench for mult_requester
module tb_mult_requester;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 128;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [63:0] prod;
  } vec_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iLoad = 1'b0;
  logic [31:0] iOperand_A = '0;
  logic [31:0] iOperand_B = '0;
  logic        oFull;
  logic        oValid_Data;
  logic [31:0] oData_A;
  logic [31:0] oData_B;
  logic        iDone;
  logic [63:0] iProd;
  logic        oAck;
  logic [63:0] oResult;
  logic        oResult_Valid;
  logic        oBusy;
  logic        oTimeout;

  always #5 Clock = ~Clock;

  mult_requester #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iLoad         (iLoad),
    .iOperand_A    (iOperand_A),
    .iOperand_B    (iOperand_B),
    .oFull         (oFull),
    .oValid_Data   (oValid_Data),
    .oData_A       (oData_A),
    .oData_B       (oData_B),
    .iDone         (iDone),
    .iProd         (iProd),
    .oAck          (oAck),
    .oResult       (oResult),
    .oResult_Valid (oResult_Valid),
    .oBusy         (oBusy),
    .oTimeout      (oTimeout)
  );

  int nVec  = 0;
  int nFail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending pairs, the one in flight, and a multiplier that answers after doneAt cycles.
  logic [63:0] pendQ[$];
  logic [63:0] resQ[$];
  bit          infl = 0;
  logic [63:0] inflProd = '0;
  int          waitCyc = 0;
  int          doneAt = 0;
  int          lat = 5;
  bit          randLat = 0;
  bit          expTimeout = 0;
  bit          modelDone = 0;
  bit          forceDone = 0;
  logic [63:0] prodDrv = '0;

  assign iDone = modelDone | forceDone;
  assign iProd = prodDrv;

  always @(posedge Clock) begin
    bit          pReset, pLoad, pDone, pBusy;
    bit          expIssue, expAck, expAbort, expValid;
    logic [63:0] pOps;
    int          preCount;
    pReset = Reset;
    pLoad  = iLoad;
    pOps   = {iOperand_A, iOperand_B};
    pDone  = iDone;
    pBusy  = oBusy;
    #1;
    if (!pReset) begin
      chk("reset oValid_Data", oValid_Data, 0);
      chk("reset oAck", oAck, 0);
      chk("reset oResult_Valid", oResult_Valid, 0);
      chk("reset oResult", oResult, 0);
      chk("reset oData_A", oData_A, 0);
      chk("reset oData_B", oData_B, 0);
      chk("reset oBusy", oBusy, 0);
      chk("reset oTimeout", oTimeout, 0);
      chk("reset oFull", oFull, 0);
      pendQ.delete();
      infl       = 0;
      waitCyc    = 0;
      expTimeout = 0;
    end else begin
      preCount = pendQ.size();
      expIssue = !pBusy && preCount > 0;
      expAck   = infl && pDone;
      expAbort = 0;
      if (infl && !pDone) begin
        waitCyc++;
        expAbort = (waitCyc == TMO);
      end
      expValid = expIssue || (infl && !pDone && !expAbort);
      chk("oValid_Data", oValid_Data, expValid);
      chk("oAck", oAck, expAck);
      chk("oResult_Valid", oResult_Valid, expAck);
      if (expAck) begin
        chk("oResult", oResult, inflProd);
        resQ.push_back(oResult);
        infl = 0;
      end
      if (expAbort) begin
        expTimeout = 1;
        infl = 0;
      end
      chk("oTimeout", oTimeout, expTimeout);
      if (expIssue) begin
        chk("issued oData_A", oData_A, pendQ[0][63:32]);
        chk("issued oData_B", oData_B, pendQ[0][31:0]);
        inflProd = {32'b0, pendQ[0][63:32]} * {32'b0, pendQ[0][31:0]};
        void'(pendQ.pop_front());
        infl    = 1;
        waitCyc = 0;
        doneAt  = randLat ? int'($urandom_range(0, 8)) : lat;
      end
      if (pLoad && (preCount < DEPTH || expIssue)) begin
        pendQ.push_back(pOps);
      end
      chk("oFull", oFull, pendQ.size() == DEPTH);
      if (expValid || expAck) begin
        chk("oBusy", oBusy, 1);
      end
    end
    modelDone = infl && doneAt >= 0 && waitCyc >= doneAt;
    prodDrv   = modelDone ? inflProd : {$urandom, $urandom};
  end

  task automatic step();
    @(posedge Clock);
    #2;
  endtask

  task automatic waitIdle(input string name);
    int g = 0;
    while (oBusy && g < 600) begin
      step();
      g++;
    end
    chk(name, oBusy, 0);
  endtask

  task automatic waitRes(input int n, input string name);
    int g = 0;
    while (resQ.size() < n && g < 1500) begin
      step();
      g++;
    end
    chk(name, resQ.size(), n);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] b);
    iLoad      = 1'b1;
    iOperand_A = a;
    iOperand_B = b;
    step();
    iLoad = 1'b0;
  endtask

  vec_t tbl[7];

  initial begin
    logic [63:0] expL[6];
    int          g;
    int          cyc;
    bit          sawLow;

    tbl[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 70, 64'hFFFF_FFFE_0000_0001};
    tbl[1] = '{32'd3, 32'd5, 2, 64'd15};
    tbl[2] = '{32'd7, 32'd9, 0, 64'd63};
    tbl[3] = '{32'd0, 32'd12345, 5, 64'd0};
    tbl[4] = '{32'd9, 32'd9, TMO - 1, 64'd81};
    tbl[5] = '{32'h0001_0000, 32'h0001_0000, 1, 64'h1_0000_0000};
    tbl[6] = '{32'hFFFF_FFFF, 32'd2, 3, 64'h1_FFFF_FFFE};

    Reset = 1'b0;
    repeat (3) step();
    Reset = 1'b1;
    step();

    // Single transactions from the table, each into an empty idle requester.
    for (int i = 0; i < 7; i++) begin
      waitIdle("idle before vector");
      resQ.delete();
      lat = tbl[i].lat;
      load(tbl[i].a, tbl[i].b);
      step();
      chk("issue one cycle after load", oValid_Data, 1);
      waitRes(1, "vector result arrives");
      if (resQ.size() > 0) chk("vector product", resQ[0], tbl[i].prod);
    end

    // Back-to-back loads come out in order.
    waitIdle("idle before burst");
    resQ.delete();
    lat = 3;
    iLoad = 1'b1;
    iOperand_A = 32'd3; iOperand_B = 32'd5;     step();
    iOperand_A = 32'd7; iOperand_B = 32'd9;     step();
    iOperand_A = 32'd0; iOperand_B = 32'd12345; step();
    iLoad = 1'b0;
    waitRes(3, "burst results arrive");
    if (resQ.size() == 3) begin
      chk("burst result 0", resQ[0], 64'd15);
      chk("burst result 1", resQ[1], 64'd63);
      chk("burst result 2", resQ[2], 64'd0);
    end

    // Fill the buffer behind a slow transaction, then load while full during the pop.
    waitIdle("idle before fill");
    resQ.delete();
    lat = 40;
    load(32'd11, 32'd11);
    step();
    lat = 2;
    for (int k = 0; k < 5; k++) begin
      iLoad      = 1'b1;
      iOperand_A = 32'(k + 1);
      iOperand_B = 32'(100 + k);
      step();
      if (k == 3) chk("full after 4th load", oFull, 1);
      if (k == 4) chk("full after dropped 5th load", oFull, 1);
    end
    iOperand_A = 32'd6;
    iOperand_B = 32'd7;
    g = 0;
    sawLow = 0;
    while (g < 200 && !(sawLow && oValid_Data)) begin
      step();
      if (!oValid_Data) sawLow = 1;
      g++;
    end
    iLoad = 1'b0;
    chk("next issue after slow one", sawLow && oValid_Data, 1);
    chk("full after pop with push", oFull, 1);
    waitRes(6, "fill results arrive");
    expL = '{64'd121, 64'd100, 64'd202, 64'd306, 64'd412, 64'd42};
    if (resQ.size() == 6) begin
      for (int k = 0; k < 6; k++) chk("fill result", resQ[k], expL[k]);
    end

    // An entry whose product never arrives is aborted; the next one still completes.
    waitIdle("idle before timeout");
    resQ.delete();
    lat = -1;
    load(32'd2, 32'd2);
    step();
    chk("stalled entry issued", oValid_Data, 1);
    lat = 4;
    load(32'd4, 32'd4);
    cyc = 1;
    while (!oTimeout && cyc < 400) begin
      step();
      cyc++;
    end
    chk("cycles until abort", cyc, TMO);
    chk("valid low after abort", oValid_Data, 0);
    waitRes(1, "result after abort");
    if (resQ.size() == 1) chk("result after abort", resQ[0], 64'd16);
    repeat (5) step();
    chk("timeout sticky", oTimeout, 1);

    // Random loads and multiplier latencies against the model.
    randLat = 1;
    for (int c = 0; c < 400; c++) begin
      iLoad      = ($urandom_range(0, 2) == 0);
      iOperand_A = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      iOperand_B = $urandom;
      step();
    end
    iLoad   = 1'b0;
    randLat = 0;
    lat     = 3;
    g = 0;
    while ((oBusy || pendQ.size() != 0) && g < 3000) begin
      step();
      g++;
    end
    chk("random drain empty", pendQ.size(), 0);

    // Reset in the middle of a transaction with iDone held high.
    waitIdle("idle before reset test");
    lat = -1;
    load(32'd5, 32'd5);
    load(32'd6, 32'd6);
    step();
    chk("pre-reset issuing", oValid_Data, 1);
    Reset     = 1'b0;
    forceDone = 1'b1;
    step();
    chk("no ack on reset", oAck, 0);
    Reset = 1'b1;
    repeat (4) step();
    chk("idle after reset", oBusy, 0);
    chk("no issue after reset", oValid_Data, 0);
    chk("iDone ignored in idle", oResult_Valid, 0);
    forceDone = 1'b0;
    lat = 2;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", nVec);
    $fatal(1);
  end

endmodule
